elelock_ctrl: RTL and testbench
===============================

Name: elelock_ctrl

Overview:
Supervisory controller for the electronic lock keypad datapath. It consumes debounced, encoded keypad events and decides when the lock opens and closes. It holds the programmable PIN, counts failed attempts, enforces a timed lockout, auto-relocks an idle open door, and supports PIN re-programming while unlocked.

Parameters:
MAX_FAIL, 3, consecutive wrong PIN entries that trigger lockout (1..15)
LOCKOUT_CYC, 1000, lockout duration in ck cycles (1..2^CNT_W-1)
RELOCK_CYC, 5000, idle cycles in UNLOCKED before automatic relock (1..2^CNT_W-1)
DEFAULT_PIN, 16'h5963, PIN after reset; 4 BCD digits, first-entered digit in [15:12]
CNT_W, 16, width of the shared lockout/relock timer

Ports:
ck  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
key_vld  in  1  one-cycle pulse: key_code valid
key_code  in  4  digit 0-9; codes 10-15 ignored
enter  in  1  one-cycle pulse: submit entry
close  in  1  one-cycle pulse: door closed / lock request
prog  in  1  one-cycle pulse: enter PIN programming (UNLOCKED only)
lock  out  1  1 = bolt engaged
lockout  out  1  1 while in LOCKOUT
alarm  out  1  see Optional Feature
state  out  3  debug state code: UNLOCKED=0, LOCKED=1, LOCKOUT=2, PROG=3

Behaviour:
- All outputs are registered. Each output changes on the ck edge that samples the causing pulse (1-cycle latency).
- Reset (asynchronous, active-high), with the same effect mid-operation:
  - state=UNLOCKED, lock=0, lockout=0, alarm=0
  - pin=DEFAULT_PIN, digit buffer=16'hFFFF, digit count=0, fail_cnt=0, timer=0
- Digit buffer: 4-nibble shift register; a new digit enters [3:0] and older digits shift left. Digit count saturates at 4. key_vld with key_code>9 has no effect.
- Input priority within one cycle: reset > close > enter > prog > key_vld. A key_vld coinciding with enter is dropped.
- UNLOCKED:
  - timer counts up from 0.
  - close -> LOCKED.
  - timer reaching RELOCK_CYC-1 -> LOCKED (auto-relock).
  - prog -> PROG; buffer and count are cleared and the timer is held.
  - key_vld and enter are ignored.
- LOCKED (lock=1):
  - key_vld shifts in a digit.
  - enter with count==4 and buffer==pin -> UNLOCKED; lock=0, fail_cnt=0, timer=0.
  - enter otherwise (mismatch or count<4) -> fail_cnt+1.
    - If the new fail_cnt==MAX_FAIL -> LOCKOUT, timer=LOCKOUT_CYC.
    - Otherwise remain in LOCKED.
  - Every enter clears the buffer to FFFF and count to 0.
  - close is a no-op.
- LOCKOUT (lock=1, lockout=1):
  - All inputs except reset are ignored.
  - timer decrements by 1 each cycle. At timer==1 the next state is LOCKED, fail_cnt=0, lockout=0.
  - Total lockout = LOCKOUT_CYC cycles.
- PROG (lock=0):
  - key_vld shifts in a digit.
  - enter with count==4 -> pin=buffer, then UNLOCKED with timer=0.
  - enter with count<4 -> pin unchanged, UNLOCKED.
  - close -> abort (pin unchanged), LOCKED.
  - No relock timeout.
- Buffer and count are cleared on every state transition.
- fail_cnt is preserved across LOCKED only; it clears on unlock, on lockout expiry and on reset.
- More than 4 digits before enter: only the last 4 digits count.

Optional Feature:
ELELOCK_ALARM_EN.
- Defined:
  - alarm is set on entry to LOCKOUT.
  - alarm stays set after lockout expiry and clears only on a successful unlock or reset.
  - A wrong entry while alarm=1 immediately re-enters LOCKOUT, regardless of fail_cnt.
- Undefined:
  - alarm is tied 0.
  - Lockout is triggered only by fail_cnt.

Test Plan:
1. Reset, close, digits 5,9,6,3, enter -> lock 0->1 after close, 1->0 one cycle after enter; state=0.
2. LOCKED, digits 1,2,3,4 + enter three times (MAX_FAIL=3, LOCKOUT_CYC=8) -> lockout=1 for exactly 8 cycles. A correct 5963 entered during lockout is ignored. After lockout, 5963 unlocks.
3. UNLOCKED with RELOCK_CYC=20, no input -> lock=1 and state=1 after exactly 20 cycles. A close at cycle 5 locks at cycle 6.
4. UNLOCKED: prog, then digits 1,2,3,4, enter, close, then 1,2,3,4 + enter -> unlocks. The old 5963 is rejected and fail_cnt increments. prog followed by 2 digits + enter keeps the PIN at 1234.
5. LOCKED: digits 7,5,9,6,3 + enter -> unlock (last 4 digits). Digit 3 + enter in the same cycle as close -> close wins, digit dropped. key_code=4'hA is ignored.
6. Assert reset mid-LOCKOUT and mid-PROG -> lock=0, lockout=0, alarm=0, PIN back to 5963. With ELELOCK_ALARM_EN defined, alarm latches through lockout expiry and a further wrong entry re-enters LOCKOUT.

Source files
------------

// File: rtl/elelock_ctrl.sv
// elelock_ctrl: supervisory controller for the electronic lock keypad datapath.
// Holds the programmable PIN, counts failed attempts, runs a timed lockout,
// auto-relocks an idle open door and supports PIN re-programming while open.
// Optional feature macro: ELELOCK_ALARM_EN (sticky alarm that re-arms lockout).
module elelock_ctrl #(
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCKOUT_CYC = 1000,
    parameter int unsigned RELOCK_CYC  = 5000,
    parameter logic [15:0] DEFAULT_PIN = 16'h5963,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       key_vld,
    input  logic [3:0] key_code,
    input  logic       enter,
    input  logic       close,
    input  logic       prog,
    output logic       lock,
    output logic       lockout,
    output logic       alarm,
    output logic [2:0] state
);

    localparam int unsigned PIN_W   = 16;
    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned NDIG_W  = 3;
    localparam int unsigned FAIL_W  = 4;

    localparam logic [NDIG_W-1:0] NDIG_FULL   = NDIG_W'(4);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAIL);
    localparam logic [CNT_W-1:0]  RELOCK_LAST = CNT_W'(RELOCK_CYC - 1);
    localparam logic [CNT_W-1:0]  LOCKOUT_LD  = CNT_W'(LOCKOUT_CYC);
    localparam logic [CNT_W-1:0]  TIMER_ONE   = CNT_W'(1);
    localparam logic [PIN_W-1:0]  BUF_EMPTY   = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_UNLOCKED = 3'd0,
        ST_LOCKED   = 3'd1,
        ST_LOCKOUT  = 3'd2,
        ST_PROG     = 3'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PIN_W-1:0]    pin_q, pin_d;
    logic [PIN_W-1:0]    buf_q, buf_d;
    logic [NDIG_W-1:0]   ndig_q, ndig_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic                lock_d, lockout_d, alarm_q, alarm_d;

    logic                digit_ok_c;
    logic [PIN_W-1:0]    buf_shift_c;
    logic [NDIG_W-1:0]   ndig_inc_c;
    logic                pin_ok_c;
    logic [FAIL_W-1:0]   fail_inc_c;
    logic                alarm_trip_c;

    // Keypad helpers: digit qualification, shift-in value, saturating count.
    always_comb begin
        digit_ok_c  = key_vld && (key_code <= DIGIT_W'(9));
        buf_shift_c = {buf_q[PIN_W-DIGIT_W-1:0], key_code};
        ndig_inc_c  = (ndig_q == NDIG_FULL) ? ndig_q : ndig_q + NDIG_W'(1);
        pin_ok_c    = (ndig_q == NDIG_FULL) && (buf_q == pin_q);
        fail_inc_c  = fail_q + FAIL_W'(1);
`ifdef ELELOCK_ALARM_EN
        alarm_trip_c = alarm_q;
`else
        alarm_trip_c = 1'b0;
`endif
    end

    // Next-state and next-output logic; input priority close > enter > prog > key.
    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        buf_d   = buf_q;
        ndig_d  = ndig_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        alarm_d = alarm_q;

        unique case (state_q)
            ST_UNLOCKED: begin
                if (close) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end else if (timer_q == RELOCK_LAST) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end else if (prog) begin
                    // timer is held while programming
                    state_d = ST_PROG;
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end

            ST_LOCKED: begin
                if (close) begin
                    // door already bolted; close has nothing to do
                end else if (enter) begin
                    buf_d  = BUF_EMPTY;
                    ndig_d = '0;
                    if (pin_ok_c) begin
                        state_d = ST_UNLOCKED;
                        fail_d  = '0;
                        timer_d = '0;
                        alarm_d = 1'b0;
                    end else begin
                        fail_d = fail_inc_c;
                        if ((fail_inc_c == FAIL_LIMIT) || alarm_trip_c) begin
                            state_d = ST_LOCKOUT;
                            timer_d = LOCKOUT_LD;
                        end
                    end
                end else if (digit_ok_c) begin
                    buf_d  = buf_shift_c;
                    ndig_d = ndig_inc_c;
                end
            end

            ST_LOCKOUT: begin
                // every input except reset is ignored here
                if (timer_q <= TIMER_ONE) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end

            ST_PROG: begin
                if (close) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end else if (enter) begin
                    if (ndig_q == NDIG_FULL) begin
                        pin_d = buf_q;
                    end
                    state_d = ST_UNLOCKED;
                    timer_d = '0;
                end else if (digit_ok_c) begin
                    buf_d  = buf_shift_c;
                    ndig_d = ndig_inc_c;
                end
            end

            default: begin
                state_d = ST_UNLOCKED;
                timer_d = '0;
            end
        endcase

        // entry to any new state starts with an empty digit buffer
        if (state_d != state_q) begin
            buf_d  = BUF_EMPTY;
            ndig_d = '0;
        end

`ifdef ELELOCK_ALARM_EN
        if ((state_d == ST_LOCKOUT) && (state_q != ST_LOCKOUT)) begin
            alarm_d = 1'b1;
        end
`else
        alarm_d = 1'b0;
`endif

        lock_d    = (state_d == ST_LOCKED) || (state_d == ST_LOCKOUT);
        lockout_d = (state_d == ST_LOCKOUT);
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q <= ST_UNLOCKED;
            pin_q   <= DEFAULT_PIN;
            buf_q   <= BUF_EMPTY;
            ndig_q  <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            lock    <= 1'b0;
            lockout <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            buf_q   <= buf_d;
            ndig_q  <= ndig_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            lock    <= lock_d;
            lockout <= lockout_d;
            alarm_q <= alarm_d;
        end
    end

    // Debug state code and alarm come straight from registers.
    always_comb begin
        state = state_q;
        alarm = alarm_q;
    end

endmodule

// File: tb/tb_elelock_ctrl.sv
// tb_elelock_ctrl: directed scoreboard bench for elelock_ctrl
// (MAX_FAIL=3, LOCKOUT_CYC=8, RELOCK_CYC=20). Honors ELELOCK_ALARM_EN.
module tb_elelock_ctrl;

    logic       ck = 1'b0;
    logic       reset = 1'b1;
    logic       key_vld = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       enter = 1'b0;
    logic       close = 1'b0;
    logic       prog = 1'b0;
    logic       lock, lockout, alarm;
    logic [2:0] state;

    // observed vector layout: {lock, lockout, alarm, state[2:0]}
    localparam logic [5:0] UNL = 6'b000_000;
    localparam logic [5:0] LKD = 6'b100_001;
    localparam logic [5:0] LKO = 6'b110_010;
    localparam logic [5:0] PRG = 6'b000_011;
`ifdef ELELOCK_ALARM_EN
    localparam logic [5:0] ALM = 6'b001_000;
`else
    localparam logic [5:0] ALM = 6'b000_000;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [5:0] sb_exp[$];
    string      sb_tag[$];

    elelock_ctrl #(
        .MAX_FAIL   (3),
        .LOCKOUT_CYC(8),
        .RELOCK_CYC (20),
        .DEFAULT_PIN(16'h5963),
        .CNT_W      (16)
    ) dut (
        .ck      (ck),
        .reset   (reset),
        .key_vld (key_vld),
        .key_code(key_code),
        .enter   (enter),
        .close   (close),
        .prog    (prog),
        .lock    (lock),
        .lockout (lockout),
        .alarm   (alarm),
        .state   (state)
    );

    always #5 ck = ~ck;

    task automatic check_pop();
        logic [5:0] exp;
        logic [5:0] obs;
        string      tag;
        exp = sb_exp.pop_front();
        tag = sb_tag.pop_front();
        obs = {lock, lockout, alarm, state};
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, queue expectation, compare after the edge
    task automatic cyc(input string tag, input logic c, input logic e,
                       input logic p, input logic kv, input logic [3:0] kc,
                       input logic [5:0] exp);
        @(negedge ck);
        close    = c;
        enter    = e;
        prog     = p;
        key_vld  = kv;
        key_code = kc;
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        @(posedge ck);
        #1;
        check_pop();
    endtask

    task automatic idle(input string tag, input logic [5:0] exp);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, exp);
    endtask

    task automatic key(input string tag, input logic [3:0] d, input logic [5:0] exp);
        cyc(tag, 1'b0, 1'b0, 1'b0, 1'b1, d, exp);
    endtask

    task automatic do_close(input string tag, input logic [5:0] exp);
        cyc(tag, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, exp);
    endtask

    task automatic do_enter(input string tag, input logic [5:0] exp);
        cyc(tag, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, exp);
    endtask

    // four digits (outputs unchanged during keying) followed by enter
    task automatic pin4(input string tag, input logic [15:0] pin,
                        input logic [5:0] exp_key, input logic [5:0] exp_ent);
        key(tag, pin[15:12], exp_key);
        key(tag, pin[11:8],  exp_key);
        key(tag, pin[7:4],   exp_key);
        key(tag, pin[3:0],   exp_key);
        do_enter(tag, exp_ent);
    endtask

    // asynchronous reset pulse, checked before any clock edge
    task automatic pulse_reset(input string tag);
        @(negedge ck);
        close = 1'b0; enter = 1'b0; prog = 1'b0; key_vld = 1'b0; key_code = 4'd0;
        reset = 1'b1;
        #1;
        sb_exp.push_back(UNL);
        sb_tag.push_back(tag);
        check_pop();
        @(negedge ck);
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset, lock, unlock with default PIN
        repeat (3) @(posedge ck);
        #1;
        sb_exp.push_back(UNL);
        sb_tag.push_back("reset_state");
        check_pop();
        @(negedge ck);
        reset = 1'b0;
        do_close("t1_close", LKD);
        pin4("t1_unlock", 16'h5963, LKD, UNL);

        // 2: three wrong entries -> 8-cycle lockout ignoring input, then unlock
        do_close("t2_close", LKD);
        pin4("t2_wrong1", 16'h1234, LKD, LKD);
        pin4("t2_wrong2", 16'h1234, LKD, LKD);
        pin4("t2_wrong3", 16'h1234, LKD, LKO | ALM);
        pin4("t2_ignored", 16'h5963, LKO | ALM, LKO | ALM);
        idle("t2_lko6", LKO | ALM);
        idle("t2_lko7", LKO | ALM);
        idle("t2_expire", LKD | ALM);
        pin4("t2_unlock", 16'h5963, LKD | ALM, UNL);

        // 3: auto-relock after exactly 20 idle cycles, then manual close
        for (int i = 1; i <= 20; i++) begin
            idle("t3_relock", (i == 20) ? LKD : UNL);
        end
        pin4("t3_unlock", 16'h5963, LKD, UNL);
        for (int i = 1; i <= 4; i++) idle("t3_idle", UNL);
        do_close("t3_close5", LKD);
        idle("t3_hold", LKD);

        // 4: programming a new PIN, old PIN rejected, short entry keeps PIN
        pin4("t4_unlock", 16'h5963, LKD, UNL);
        cyc("t4_prog", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, PRG);
        pin4("t4_newpin", 16'h1234, PRG, UNL);
        do_close("t4_close", LKD);
        pin4("t4_oldpin", 16'h5963, LKD, LKD);
        pin4("t4_newok", 16'h1234, LKD, UNL);
        cyc("t4_prog2", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, PRG);
        for (int i = 0; i < 25; i++) idle("t4_noreloc", PRG);
        key("t4_short", 4'd7, PRG);
        key("t4_short", 4'd7, PRG);
        do_enter("t4_short_ent", UNL);
        do_close("t4_close2", LKD);
        pin4("t4_kept", 16'h1234, LKD, UNL);

        // 5: close no-op in LOCKED, last-4-digits, priority, invalid codes
        do_close("t5_close", LKD);
        key("t5_k", 4'd1, LKD);
        key("t5_k", 4'd2, LKD);
        do_close("t5_close_nop", LKD);
        key("t5_k", 4'd3, LKD);
        key("t5_k", 4'd4, LKD);
        do_enter("t5_nop_unlock", UNL);
        do_close("t5_close2", LKD);
        key("t5_five", 4'd7, LKD);
        pin4("t5_last4", 16'h1234, LKD, UNL);
        cyc("t5_close_wins", 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, LKD);
        key("t5_k", 4'd1, LKD);
        key("t5_k", 4'd2, LKD);
        key("t5_k", 4'd3, LKD);
        cyc("t5_key_ent", 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, LKD);
        key("t5_k", 4'd1, LKD);
        key("t5_k", 4'd2, LKD);
        key("t5_k", 4'd3, LKD);
        key("t5_k", 4'd4, LKD);
        key("t5_codeA", 4'hA, LKD);
        do_enter("t5_ignoreA", UNL);

        // 6: reset mid-lockout and mid-programming restores defaults
        do_close("t6_close", LKD);
        pin4("t6_wrong1", 16'h1111, LKD, LKD);
        pin4("t6_wrong2", 16'h1111, LKD, LKD);
        pin4("t6_wrong3", 16'h1111, LKD, LKO | ALM);
        idle("t6_lko", LKO | ALM);
        pulse_reset("t6_rst_lockout");
        do_close("t6_close2", LKD);
        pin4("t6_default", 16'h5963, LKD, UNL);
        cyc("t6_prog", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, PRG);
        for (int i = 0; i < 4; i++) key("t6_pk", 4'd1, PRG);
        pulse_reset("t6_rst_prog");
        do_close("t6_close3", LKD);
        pin4("t6_default2", 16'h5963, LKD, UNL);

        // alarm latch through expiry; wrong entry afterwards
        do_close("t6_close4", LKD);
        pin4("t6a_wrong1", 16'h2222, LKD, LKD);
        pin4("t6a_wrong2", 16'h2222, LKD, LKD);
        pin4("t6a_wrong3", 16'h2222, LKD, LKO | ALM);
        for (int i = 0; i < 7; i++) idle("t6a_lko", LKO | ALM);
        idle("t6a_expire", LKD | ALM);
`ifdef ELELOCK_ALARM_EN
        pin4("t6a_rearm", 16'h2222, LKD | ALM, LKO | ALM);
        for (int i = 0; i < 7; i++) idle("t6a_lko2", LKO | ALM);
        idle("t6a_expire2", LKD | ALM);
`else
        pin4("t6a_single", 16'h2222, LKD, LKD);
`endif
        pin4("t6a_unlock", 16'h5963, LKD | ALM, UNL);

        idle("end_idle", UNL);
        n_cmp++;
        assert (sb_exp.size() == 0)
        else begin
            n_err++;
            $error("FAIL sb_drain: observed %0d expected 0", sb_exp.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
